// File: rtl/fib_seq_gen.sv
// Fibonacci-type sequence generator with a valid/ready output stream.
// Emits `count` terms from two seeds; overflow either wraps or ends the sequence early.
module fib_seq_gen #(
    parameter int WIDTH = 16,
    parameter int IDX_W = 8,
    parameter int SEED0 = 0,
    parameter int SEED1 = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [IDX_W-1:0] count,
    input  logic             wrap_en,
    output logic [WIDTH-1:0] out_data,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             busy,
    output logic             ovf
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] SEED0_V = WIDTH'(SEED0);
    localparam logic [WIDTH-1:0] SEED1_V = WIDTH'(SEED1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               a_ovf_q, a_ovf_d;
    logic               b_ovf_q, b_ovf_d;
    logic [IDX_W-1:0]   rem_q, rem_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               wrap_q, wrap_d;
    logic               last_q, last_d;
    logic               ovf_q, ovf_d;

    logic [WIDTH:0]     sum_s;
    logic [IDX_W-1:0]   rem_dec_s;
    logic               hs_s;

    assign sum_s     = {1'b0, a_q} + {1'b0, b_q};
    assign rem_dec_s = rem_q - IDX_W'(1);
    assign hs_s      = (state_q == ST_RUN) && out_ready;

    // Next-state logic: sequence load, term advance and overflow tracking.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        a_ovf_d = a_ovf_q;
        b_ovf_d = b_ovf_q;
        rem_d   = rem_q;
        idx_d   = idx_q;
        wrap_d  = wrap_q;
        last_d  = last_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (start && (count != '0)) begin
                    state_d = ST_RUN;
                    a_d     = SEED0_V;
                    b_d     = SEED1_V;
                    a_ovf_d = 1'b0;
                    b_ovf_d = 1'b0;
                    rem_d   = count;
                    idx_d   = '0;
                    wrap_d  = wrap_en;
                    ovf_d   = 1'b0;
                    last_d  = (count == IDX_W'(1));
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (hs_s) begin
                    // In stop mode the last beat is flagged when the following term overflowed.
                    if ((wrap_q && a_ovf_q) || (!wrap_q && last_q && b_ovf_q)) begin
                        ovf_d = 1'b1;
                    end else begin
                        ovf_d = ovf_q;
                    end
                    if (last_q) begin
                        state_d = ST_IDLE;
                        last_d  = 1'b0;
                    end else begin
                        a_d     = b_q;
                        a_ovf_d = b_ovf_q;
                        b_d     = sum_s[WIDTH-1:0];
                        b_ovf_d = sum_s[WIDTH] | a_ovf_q | b_ovf_q;
                        idx_d   = idx_q + IDX_W'(1);
                        rem_d   = rem_dec_s;
                        last_d  = (rem_dec_s == IDX_W'(1)) || (!wrap_q && b_ovf_d);
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            a_ovf_q <= 1'b0;
            b_ovf_q <= 1'b0;
            rem_q   <= '0;
            idx_q   <= '0;
            wrap_q  <= 1'b0;
            last_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            a_ovf_q <= a_ovf_d;
            b_ovf_q <= b_ovf_d;
            rem_q   <= rem_d;
            idx_q   <= idx_d;
            wrap_q  <= wrap_d;
            last_q  <= last_d;
            ovf_q   <= ovf_d;
        end
    end

    assign out_data  = a_q;
    assign out_idx   = idx_q;
    assign out_valid = (state_q == ST_RUN);
    assign busy      = (state_q == ST_RUN);
    assign out_last  = last_q;
    assign ovf       = ovf_q;

endmodule
